// File: rtl/door_ctrl_timed_if.sv
// door_ctrl_timed_if: signal bundle between the door controller and its
// environment (debounced switches/sensors in, motor drive and status out).
// Signalling: every signal is a plain level, sampled on the rising clock
// edge. There is no valid/ready handshake; a request is simply held or
// pulsed high. The dbg_* signals mirror the controller state register and
// timer so checkers can observe them directly.
interface door_ctrl_timed_if #(
  parameter int CNT_W = 16
);
  logic             Activate;
  logic             Up_Max;
  logic             Dn_Max;
  logic             Obstruct;
  logic             Fault_Clr;
  logic             Up_M;
  logic             Dn_M;
  logic             Fault;
  logic             Hold;
  logic [2:0]       dbg_state;
  logic [CNT_W-1:0] dbg_timer;

  // Environment side: drives requests and sensors, observes the controller.
  modport master (
    output Activate, Up_Max, Dn_Max, Obstruct, Fault_Clr,
    input  Up_M, Dn_M, Fault, Hold, dbg_state, dbg_timer
  );

  // Controller side.
  modport slave (
    input  Activate, Up_Max, Dn_Max, Obstruct, Fault_Clr,
    output Up_M, Dn_M, Fault, Hold, dbg_state, dbg_timer
  );
endinterface

// File: rtl/door_ctrl_timed.sv
// door_ctrl_timed: timer-supervised garage/gate door controller.
// Moore FSM (IDLE, MV_UP, MV_DN, HOLD, FAULT) driving an up/down motor from
// a level-sampled Activate request and two limit switches. Adds a motor-run
// timeout to a latched FAULT, obstruction/Activate reversal while closing
// and limit-switch conflict detection.
// Optional feature macro: DOOR_AUTO_CLOSE_EN. When defined, reaching the
// upper limit enters HOLD and the door auto-closes after HOLD_CYCLES; when
// undefined, the door stops in IDLE at the top and Hold is tied low.
module door_ctrl_timed #(
  parameter int CNT_W        = 16,
  parameter int MOVE_TIMEOUT = 1000,
  parameter int HOLD_CYCLES  = 500
) (
  input  logic             CLK,
  input  logic             RST,
  door_ctrl_timed_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MV_UP = 3'd1,
    S_MV_DN = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

`ifdef DOOR_AUTO_CLOSE_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  // Terminal counts: the timer reads 0 in the first cycle of a state, so the
  // last allowed cycle is N-1.
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             timer_clr;
  logic             both_lim;

  assign both_lim = bus.Up_Max & bus.Dn_Max;

  // State and timer registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state decode; timer_clr handles the HOLD obstruction restart where
  // the state itself does not change.
  always_comb begin
    state_d   = state_q;
    timer_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (both_lim)                         state_d = S_FAULT;
        else if (bus.Activate && bus.Up_Max)  state_d = S_MV_DN;
        else if (bus.Activate)                state_d = S_MV_UP; // at bottom or mid-travel
      end
      S_MV_UP: begin
        if (both_lim)                state_d = S_FAULT;
        else if (bus.Up_Max)         state_d = HOLD_EN ? S_HOLD : S_IDLE;
        else if (timer_q == MOVE_LAST) state_d = S_FAULT;
      end
      S_MV_DN: begin
        if (both_lim)                          state_d = S_FAULT;
        else if (bus.Dn_Max)                   state_d = S_IDLE;
        else if (bus.Obstruct || bus.Activate) state_d = S_MV_UP;
        else if (timer_q == MOVE_LAST)         state_d = S_FAULT;
      end
      S_HOLD: begin
        if (!HOLD_EN)                    state_d = S_IDLE;
        else if (bus.Obstruct)           timer_clr = 1'b1;
        else if (bus.Activate)           state_d = S_MV_DN;
        else if (timer_q == HOLD_LAST)   state_d = S_MV_DN;
      end
      S_FAULT: begin
        if (bus.Fault_Clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timer: restart on any state change or obstruction in HOLD, otherwise
  // count (saturating) while the motor runs or the door holds open.
  always_comb begin
    timer_d = timer_q;
    if ((state_d != state_q) || timer_clr) begin
      timer_d = '0;
    end else if ((state_q == S_MV_UP) || (state_q == S_MV_DN) ||
                 (HOLD_EN && (state_q == S_HOLD))) begin
      if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
    end
  end

  assign bus.Up_M      = (state_q == S_MV_UP);
  assign bus.Dn_M      = (state_q == S_MV_DN);
  assign bus.Fault     = (state_q == S_FAULT);
  assign bus.Hold      = HOLD_EN && (state_q == S_HOLD);
  assign bus.dbg_state = state_q;
  assign bus.dbg_timer = timer_q;

endmodule

// File: tb/tb_door_ctrl_timed.sv
// tb_door_ctrl_timed: directed bench for door_ctrl_timed with
// MOVE_TIMEOUT=8 and HOLD_CYCLES=4. Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point, so each sample shows the
// effect of the edge just taken. Auto-close scenarios build only when
// DOOR_AUTO_CLOSE_EN is defined.
module tb_door_ctrl_timed;

  localparam int CNT_W = 16;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MV_UP = 3'd1;
  localparam logic [2:0] ST_MV_DN = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  door_ctrl_timed_if #(.CNT_W(CNT_W)) bus ();

  door_ctrl_timed #(
    .CNT_W(CNT_W),
    .MOVE_TIMEOUT(8),
    .HOLD_CYCLES(4)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Activate  = 1'b0;
    bus.Up_Max    = 1'b0;
    bus.Dn_Max    = 1'b0;
    bus.Obstruct  = 1'b0;
    bus.Fault_Clr = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got %0d exp %0d", bus.dbg_state, ST_IDLE);
    end
    checks++;
    if (bus.dbg_timer !== '0) begin
      errors++; $display("FAIL reset_timer got %0d exp 0", bus.dbg_timer);
    end
    checks++;
    if ({bus.Up_M, bus.Dn_M, bus.Fault, bus.Hold} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000",
                         {bus.Up_M, bus.Dn_M, bus.Fault, bus.Hold});
    end
    rst = 1'b0;
  endtask

  task automatic test_open();
    int n;
    do_reset();
    bus.Dn_Max = 1'b1; bus.Activate = 1'b1;
    tick();
    bus.Activate = 1'b0; bus.Dn_Max = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && bus.Up_M === 1'b1; i++) begin
      n++;
      if (n == 5) bus.Up_Max = 1'b1;
      tick();
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL open_up_cycles got %0d exp 5", n);
    end
    checks++;
    if ({bus.Up_M, bus.Dn_M, bus.Fault} !== 3'b000) begin
      errors++; $display("FAIL open_end_outputs got %b exp 000", {bus.Up_M, bus.Dn_M, bus.Fault});
    end
`ifdef DOOR_AUTO_CLOSE_EN
    checks++;
    if (bus.Hold !== 1'b1) begin
      errors++; $display("FAIL open_enter_hold got %b exp 1", bus.Hold);
    end
`else
    checks++;
    if (bus.Hold !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL open_idle got hold %b state %0d exp hold 0 state 0",
                         bus.Hold, bus.dbg_state);
    end
    // No auto-close: stays open until a fresh Activate.
    tick(); tick(); tick();
    checks++;
    if (bus.dbg_state !== ST_IDLE || bus.Dn_M !== 1'b0) begin
      errors++; $display("FAIL open_stays_idle got state %0d dn %b exp 0 0",
                         bus.dbg_state, bus.Dn_M);
    end
    bus.Activate = 1'b1;
    tick();
    bus.Activate = 1'b0;
    checks++;
    if (bus.Dn_M !== 1'b1 || bus.Up_M !== 1'b0) begin
      errors++; $display("FAIL open_then_close got dn %b up %b exp 1 0", bus.Dn_M, bus.Up_M);
    end
`endif
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    bus.Dn_Max = 1'b1; bus.Activate = 1'b1;
    tick();
    bus.Activate = 1'b0; bus.Dn_Max = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && bus.Up_M === 1'b1; i++) begin
      n++;
      tick();
    end
    checks++;
    if (n != 8) begin
      errors++; $display("FAIL timeout_up_cycles got %0d exp 8", n);
    end
    checks++;
    if (bus.Fault !== 1'b1 || bus.Up_M !== 1'b0) begin
      errors++; $display("FAIL timeout_fault got fault %b up %b exp 1 0", bus.Fault, bus.Up_M);
    end
    // FAULT is latched: other inputs are ignored.
    bus.Activate = 1'b1; bus.Dn_Max = 1'b1;
    tick();
    checks++;
    if (bus.Fault !== 1'b1 || bus.Up_M !== 1'b0) begin
      errors++; $display("FAIL fault_latched got fault %b up %b exp 1 0", bus.Fault, bus.Up_M);
    end
    bus.Activate = 1'b0; bus.Dn_Max = 1'b0; bus.Fault_Clr = 1'b1;
    tick();
    bus.Fault_Clr = 1'b0;
    checks++;
    if (bus.Fault !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL fault_clear got fault %b state %0d exp 0 0",
                         bus.Fault, bus.dbg_state);
    end
  endtask

  task automatic test_limit_vs_timeout();
    int n;
    do_reset();
    bus.Dn_Max = 1'b1; bus.Activate = 1'b1;
    tick();
    bus.Activate = 1'b0; bus.Dn_Max = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && bus.Up_M === 1'b1; i++) begin
      n++;
      if (n == 8) bus.Up_Max = 1'b1;   // limit arrives in the timeout cycle
      tick();
    end
    checks++;
    if (n != 8 || bus.Fault !== 1'b0) begin
      errors++; $display("FAIL limit_beats_timeout got cycles %0d fault %b exp 8 0", n, bus.Fault);
    end
`ifdef DOOR_AUTO_CLOSE_EN
    checks++;
    if (bus.dbg_state !== ST_HOLD) begin
      errors++; $display("FAIL limit_beats_timeout_state got %0d exp %0d", bus.dbg_state, ST_HOLD);
    end
`else
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin
      errors++; $display("FAIL limit_beats_timeout_state got %0d exp %0d", bus.dbg_state, ST_IDLE);
    end
`endif
  endtask

  task automatic test_reversal();
    do_reset();
    bus.Up_Max = 1'b1; bus.Activate = 1'b1;
    tick();
    bus.Activate = 1'b0; bus.Up_Max = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (bus.Dn_M !== 1'b1 || bus.dbg_timer !== 16'd3) begin
      errors++; $display("FAIL rev_before got dn %b timer %0d exp 1 3", bus.Dn_M, bus.dbg_timer);
    end
    bus.Obstruct = 1'b1;
    tick();
    bus.Obstruct = 1'b0;
    checks++;
    if (bus.Dn_M !== 1'b0 || bus.Up_M !== 1'b1 || bus.dbg_timer !== 16'd0) begin
      errors++; $display("FAIL rev_switch got dn %b up %b timer %0d exp 0 1 0",
                         bus.Dn_M, bus.Up_M, bus.dbg_timer);
    end
    tick();
    checks++;
    if (bus.Up_M !== 1'b1 || bus.dbg_timer !== 16'd1) begin
      errors++; $display("FAIL rev_after got up %b timer %0d exp 1 1", bus.Up_M, bus.dbg_timer);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    bus.Up_Max = 1'b1; bus.Dn_Max = 1'b1;
    tick();
    checks++;
    if (bus.Fault !== 1'b1) begin
      errors++; $display("FAIL conflict_idle got fault %b exp 1", bus.Fault);
    end
    bus.Up_Max = 1'b0; bus.Dn_Max = 1'b0; bus.Fault_Clr = 1'b1;
    tick();
    bus.Fault_Clr = 1'b0;
    bus.Up_Max = 1'b1; bus.Activate = 1'b1;
    tick();
    bus.Activate = 1'b0; bus.Up_Max = 1'b0;
    tick();
    checks++;
    if (bus.Dn_M !== 1'b1 || bus.dbg_state !== ST_MV_DN) begin
      errors++; $display("FAIL conflict_setup got dn %b state %0d exp 1 2", bus.Dn_M, bus.dbg_state);
    end
    bus.Up_Max = 1'b1; bus.Dn_Max = 1'b1;
    tick();
    checks++;
    if (bus.Fault !== 1'b1 || bus.Dn_M !== 1'b0) begin
      errors++; $display("FAIL conflict_mv_dn got fault %b dn %b exp 1 0", bus.Fault, bus.Dn_M);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_travel();
    do_reset();
    bus.Up_Max = 1'b1; bus.Activate = 1'b1;
    tick();
    bus.Activate = 1'b0; bus.Up_Max = 1'b0;
    tick();
    checks++;
    if (bus.Dn_M !== 1'b1) begin
      errors++; $display("FAIL rst_mid_setup got dn %b exp 1", bus.Dn_M);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.Dn_M !== 1'b0 || bus.dbg_state !== ST_IDLE || bus.dbg_timer !== 16'd0) begin
      errors++; $display("FAIL rst_mid got dn %b state %0d timer %0d exp 0 0 0",
                         bus.Dn_M, bus.dbg_state, bus.dbg_timer);
    end
    bus.Activate = 1'b1;
    tick();
    bus.Activate = 1'b0;
    checks++;
    if (bus.Up_M !== 1'b1 || bus.dbg_state !== ST_MV_UP) begin
      errors++; $display("FAIL rst_mid_failsafe got up %b state %0d exp 1 1", bus.Up_M, bus.dbg_state);
    end
  endtask

`ifdef DOOR_AUTO_CLOSE_EN
  task automatic test_auto_close();
    int n;
    do_reset();
    bus.Dn_Max = 1'b1; bus.Activate = 1'b1;
    tick();
    bus.Activate = 1'b0; bus.Dn_Max = 1'b0;
    bus.Up_Max = 1'b1;
    tick();
    n = 0;
    for (int i = 0; i < 20 && bus.Hold === 1'b1; i++) begin
      n++;
      tick();
    end
    checks++;
    if (n != 4 || bus.Dn_M !== 1'b1) begin
      errors++; $display("FAIL auto_close got hold %0d dn %b exp 4 1", n, bus.Dn_M);
    end
    // Obstruction during HOLD restarts the hold period.
    do_reset();
    bus.Dn_Max = 1'b1; bus.Activate = 1'b1;
    tick();
    bus.Activate = 1'b0; bus.Dn_Max = 1'b0;
    bus.Up_Max = 1'b1;
    tick();
    tick();
    bus.Obstruct = 1'b1;
    tick();
    tick();
    bus.Obstruct = 1'b0;
    checks++;
    if (bus.Hold !== 1'b1 || bus.dbg_timer !== 16'd0) begin
      errors++; $display("FAIL hold_obstruct got hold %b timer %0d exp 1 0", bus.Hold, bus.dbg_timer);
    end
    n = 0;
    for (int i = 0; i < 20 && bus.Hold === 1'b1; i++) begin
      n++;
      tick();
    end
    checks++;
    if (n != 4 || bus.Dn_M !== 1'b1) begin
      errors++; $display("FAIL hold_after_obstruct got hold %0d dn %b exp 4 1", n, bus.Dn_M);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_open();
    test_timeout();
    test_limit_vs_timeout();
    test_reversal();
    test_conflict();
    test_reset_mid_travel();
`ifdef DOOR_AUTO_CLOSE_EN
    test_auto_close();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
